regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single register-file write port (w_en/wdata/waddr) between the in-order write-back path and a long-latency auxiliary unit (divider, CSR, or load-miss return). Auxiliary results are buffered in a small FIFO and drained whenever write-back leaves the port idle. An optional starvation guard stalls write-back to force a drain. Stale auxiliary results overtaken by a newer write-back to the same register are squashed, so the register file never ends up with the older value.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 6, register address width
- FIFO_DEPTH, 2, auxiliary buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive write-back wins tolerated while aux is pending (used only with RF_ARB_STARVE_EN)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  write-back result present
- wb_ready  out  1  write-back accepted this cycle
- wb_data  in  DATA_W  write-back result
- wb_addr  in  ADDR_W  write-back destination
- aux_valid  in  1  auxiliary result present
- aux_ready  out  1  FIFO can accept
- aux_data  in  DATA_W  auxiliary result
- aux_addr  in  ADDR_W  auxiliary destination
- w_en  out  1  register-file write strobe, one-cycle pulse
- wdata  out  DATA_W  write data
- waddr  out  ADDR_W  write address
- wr_src  out  2  source of the current write: 0 none, 1 wb, 2 aux
- aux_pending  out  $clog2(FIFO_DEPTH)+1  live-or-dead entries held

## Operation
- Reset (reset low): w_en=0, wdata=0, waddr=0, wr_src=0, aux_pending=0, FIFO empty, starvation counter 0. aux_ready=0 while reset is asserted.
- Handshakes: a transfer occurs when valid && ready at the rising edge. aux_ready = !full, with no pass-through. wb_ready = 1 except in a forced-drain cycle.
- FIFO entry holds {live, addr, data}. Push sets live=1.
- Arbitration, each cycle, priority order:
  - (a) forced drain of a live head, if the guard is active;
  - (b) wb_valid → grant wb;
  - (c) a live head → grant aux and pop;
  - (d) a dead head → pop silently; this does not use the port and can coincide with (b).
- Granted data is registered onto wdata/waddr with w_en=1 for exactly one cycle. Otherwise w_en=0, and wdata/waddr hold their last values.
- Address 0: the handshake completes and the entry pops, but w_en stays 0 and wr_src=0.
- Squash: when a wb transfer with wb_addr=A≠0 occurs, every FIFO entry with addr A gets live=0. This includes an aux entry pushed in the same cycle, which is defined as older.
- Starvation guard: see Configuration.

## Timing
- wb accepted at edge N → w_en high during cycle N..N+1. Latency 1.
- aux pushed at edge N → earliest grant at edge N+1 → w_en high after N+1. Latency 2.
- Full FIFO with a simultaneous pop: aux_ready is still 0 that cycle. The freed slot is visible the next cycle.
- Back-to-back grants produce back-to-back w_en pulses, with no bubble required.
- Reset asserted mid-operation: FIFO contents are discarded and w_en drops immediately (asynchronous).

## Configuration
- RF_ARB_STARVE_EN defined:
  - The counter increments on each wb grant while a live head is waiting.
  - It clears on an aux grant or when no live head exists.
  - When it reaches STARVE_LIMIT, the next cycle drives wb_ready=0 and grants the head. The counter then clears.
- RF_ARB_STARVE_EN undefined: no counter; strict wb priority; wb_ready is tied to 1 out of reset.

## Structure
- Package rf_arb_pkg:
  - src enum SRC_NONE/SRC_WB/SRC_AUX;
  - packed FIFO entry struct {live, addr, data}.
- Sub-module rf_arb_fifo: parameterised FIFO with per-entry address compare and a squash input (squash_vld, squash_addr).
- Top level: arbitration, starvation counter, and output registers.

## Test plan
- Reset release, then wb_valid with addr=5, data=0xDEADBEEF → next cycle w_en=1, waddr=5, wdata=0xDEADBEEF, wr_src=1.
- aux push with addr=7, data=0x11 while wb is idle → w_en on the second cycle after the push, wr_src=2, aux_pending 1→0.
- Three aux pushes back-to-back with wb_valid held high and no guard → aux_ready=0 on the third, and no aux write occurs until wb drops.
- With RF_ARB_STARVE_EN and STARVE_LIMIT=4: wb_valid constant, one aux entry queued → after 4 wb writes, wb_ready=0 for one cycle and the aux write occurs, then wb resumes.
- aux push with addr=9, then wb write to addr=9 before the drain → the aux entry pops with no w_en, and the final register value is the wb data.
- aux push with addr=0 → pops, w_en stays 0; reset asserted with 2 entries queued → aux_pending=0 and w_en=0 immediately.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types for the register-file write arbiter.
// The FIFO entry layout fixes the data/address widths used across the arbiter.
package rf_arb_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 6;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_AUX  = 2'd2
    } src_e;

    typedef struct packed {
        logic                 live;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_entry_t;
endpackage

// File: rtl/rf_arb_fifo.sv
// rf_arb_fifo: auxiliary result buffer; a squash clears the live bit of every
// entry (including one pushed in the same cycle) whose address matches.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  rf_entry_t              i_push_entry,
    input  logic                   i_pop,
    input  logic                   i_squash_vld,
    input  logic [RF_ADDR_W-1:0]   i_squash_addr,
    output rf_entry_t              o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rf_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_push_live;

    assign w_push_live = !(i_squash_vld && i_push_entry.addr == i_squash_addr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++)
                if (i_squash_vld && r_mem[k].addr == i_squash_addr) r_mem[k].live <= 1'b0;
            if (i_push) begin
                r_mem[r_wptr] <= '{live: w_push_live, addr: i_push_entry.addr, data: i_push_entry.data};
                r_wptr        <= r_wptr + PW'(1);
            end
            if (i_pop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between write-back
// and a buffered auxiliary unit. Define RF_ARB_STARVE_EN for the starvation guard.
module regfile_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W       = RF_DATA_W,
    parameter int ADDR_W       = RF_ADDR_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wb_valid,
    output logic                        o_wb_ready,
    input  logic [DATA_W-1:0]           i_wb_data,
    input  logic [ADDR_W-1:0]           i_wb_addr,
    input  logic                        i_aux_valid,
    output logic                        o_aux_ready,
    input  logic [DATA_W-1:0]           i_aux_data,
    input  logic [ADDR_W-1:0]           i_aux_addr,
    output logic                        o_w_en,
    output logic [DATA_W-1:0]           o_wdata,
    output logic [ADDR_W-1:0]           o_waddr,
    output logic [1:0]                  o_wr_src,
    output logic [$clog2(FIFO_DEPTH):0] o_aux_pending
);
    rf_entry_t          w_head;
    rf_entry_t          w_push_entry;
    logic               w_full;
    logic               w_empty;
    logic               w_head_live;
    logic               w_force;
    logic               w_wb_fire;
    logic               w_aux_grant;
    logic               w_pop;
    logic               w_push;
    logic               w_wr;
    logic [ADDR_W-1:0]  w_gnt_addr;
    logic [DATA_W-1:0]  w_gnt_data;

    assign w_head_live  = !w_empty && w_head.live;
    assign o_wb_ready   = !w_force;
    assign w_wb_fire    = i_wb_valid && !w_force;
    assign w_aux_grant  = w_head_live && (w_force || !i_wb_valid);
    // A dead head leaves silently, even alongside a write-back grant.
    assign w_pop        = !w_empty && (w_aux_grant || !w_head.live);
    assign o_aux_ready  = i_rst_n && !w_full;
    assign w_push       = i_aux_valid && o_aux_ready;
    assign w_push_entry = '{live: 1'b1, addr: i_aux_addr, data: i_aux_data};
    assign w_gnt_addr   = w_wb_fire ? i_wb_addr : w_head.addr;
    assign w_gnt_data   = w_wb_fire ? i_wb_data : w_head.data;
    assign w_wr         = (w_wb_fire || w_aux_grant) && w_gnt_addr != '0;

`ifdef RF_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] r_starve;

    assign w_force = w_head_live && r_starve == SW'(STARVE_LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_starve <= '0;
        else if (w_aux_grant || !w_head_live) r_starve <= '0;
        else if (w_wb_fire) r_starve <= r_starve + SW'(1);
    end
`else
    assign w_force = 1'b0;
`endif

    rf_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_push        (w_push),
        .i_push_entry  (w_push_entry),
        .i_pop         (w_pop),
        .i_squash_vld  (w_wb_fire && i_wb_addr != '0),
        .i_squash_addr (i_wb_addr),
        .o_head        (w_head),
        .o_count       (o_aux_pending),
        .o_full        (w_full),
        .o_empty       (w_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_w_en   <= 1'b0;
            o_wdata  <= '0;
            o_waddr  <= '0;
            o_wr_src <= SRC_NONE;
        end else begin
            o_w_en   <= w_wr;
            o_wr_src <= !w_wr ? SRC_NONE : w_wb_fire ? SRC_WB : SRC_AUX;
            if (w_wr) begin
                o_wdata <= w_gnt_data;
                o_waddr <= w_gnt_addr;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of the write arbiter; inputs change
// and outputs are sampled on the falling clock edge.
module tb_regfile_write_arbiter;
`ifdef RF_ARB_STARVE_EN
    localparam bit SE = 1'b1;
`else
    localparam bit SE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_ready, aux_valid, aux_ready, w_en;
    logic [31:0] wb_data, aux_data, wdata;
    logic [5:0]  wb_addr, aux_addr, waddr;
    logic [1:0]  wr_src, aux_pending;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_valid(wb_valid), .o_wb_ready(wb_ready), .i_wb_data(wb_data), .i_wb_addr(wb_addr),
        .i_aux_valid(aux_valid), .o_aux_ready(aux_ready), .i_aux_data(aux_data), .i_aux_addr(aux_addr),
        .o_w_en(w_en), .o_wdata(wdata), .o_waddr(waddr), .o_wr_src(wr_src), .o_aux_pending(aux_pending)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic drive(input logic wv, input logic [5:0] wa, input logic [31:0] wd,
                         input logic av, input logic [5:0] aa, input logic [31:0] ad);
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        aux_valid = av; aux_addr = aa; aux_data = ad;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_w_en", w_en, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wr_src", wr_src, 0);
        chk("rst_pending", aux_pending, 0);
        chk("rst_aux_ready", aux_ready, 0);
        nx(); rst_n = 1'b1;
        nx();
        chk("idle_aux_ready", aux_ready, 1);
        chk("idle_wb_ready", wb_ready, 1);
        chk("idle_w_en", w_en, 0);

        // write-back, latency 1
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        nx();
        chk("wb_w_en", w_en, 1);
        chk("wb_waddr", waddr, 5);
        chk("wb_wdata", wdata, 32'hDEADBEEF);
        chk("wb_src", wr_src, 1);
        drive(0, 0, 0, 0, 0, 0);
        nx();
        chk("wb_pulse_end", w_en, 0);
        chk("wb_hold_data", wdata, 32'hDEADBEEF);
        chk("wb_src_none", wr_src, 0);

        // aux while idle, latency 2
        drive(0, 0, 0, 1, 7, 32'h11);
        nx();
        chk("aux_pend1", aux_pending, 1);
        chk("aux_no_wen_yet", w_en, 0);
        drive(0, 0, 0, 0, 0, 0);
        nx();
        chk("aux_w_en", w_en, 1);
        chk("aux_waddr", waddr, 7);
        chk("aux_wdata", wdata, 32'h11);
        chk("aux_src", wr_src, 2);
        chk("aux_pend0", aux_pending, 0);
        nx();
        chk("aux_pulse_end", w_en, 0);

        // fill with wb held high
        drive(1, 1, 32'hA0, 1, 2, 32'hB0);
        nx();
        chk("fill1_src", wr_src, 1);
        chk("fill1_pend", aux_pending, 1);
        chk("fill1_ready", aux_ready, 1);
        drive(1, 1, 32'hA1, 1, 3, 32'hB1);
        nx();
        chk("fill2_pend", aux_pending, 2);
        chk("fill2_ready", aux_ready, 0);
        chk("fill2_wdata", wdata, 32'hA1);
        drive(1, 1, 32'hA2, 1, 4, 32'hB2);
        nx();
        chk("fill3_pend", aux_pending, 2);
        chk("fill3_ready", aux_ready, 0);
        chk("fill3_src", wr_src, 1);
        chk("fill3_wdata", wdata, 32'hA2);
        drive(0, 0, 0, 0, 0, 0);
        nx();
        chk("drain1_src", wr_src, 2);
        chk("drain1_waddr", waddr, 2);
        chk("drain1_wdata", wdata, 32'hB0);
        chk("drain1_pend", aux_pending, 1);
        chk("drain1_ready", aux_ready, 1);
        nx();
        chk("drain2_w_en", w_en, 1);
        chk("drain2_waddr", waddr, 3);
        chk("drain2_wdata", wdata, 32'hB1);
        chk("drain2_pend", aux_pending, 0);
        nx();
        chk("drain_done", w_en, 0);

        // starvation: wb held, one aux entry queued
        drive(1, 11, 32'hD0, 1, 10, 32'hC0);
        nx();
        chk("stv_first_src", wr_src, 1);
        chk("stv_pend", aux_pending, 1);
        aux_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            nx();
            chk("stv_wb_src", wr_src, 1);
            chk("stv_wb_ready", wb_ready, (SE && i == 4) ? 0 : 1);
        end
        nx();
        chk("stv_force_src", wr_src, SE ? 2 : 1);
        chk("stv_force_waddr", waddr, SE ? 10 : 11);
        chk("stv_force_pend", aux_pending, SE ? 0 : 1);
        chk("stv_resume_ready", wb_ready, 1);
        nx();
        chk("stv_resume_src", wr_src, 1);
        wb_valid = 1'b0;
        nx();
        chk("stv_tail_src", wr_src, SE ? 0 : 2);
        chk("stv_tail_waddr", waddr, SE ? 11 : 10);
        chk("stv_tail_pend", aux_pending, 0);

        // squash: newer wb to same register kills buffered aux
        drive(0, 0, 0, 1, 9, 32'h99);
        nx();
        chk("sq_pend1", aux_pending, 1);
        drive(1, 9, 32'h5A, 0, 0, 0);
        nx();
        chk("sq_wb_src", wr_src, 1);
        chk("sq_wb_data", wdata, 32'h5A);
        chk("sq_dead_pend", aux_pending, 1);
        drive(0, 0, 0, 0, 0, 0);
        nx();
        chk("sq_no_wen", w_en, 0);
        chk("sq_pend0", aux_pending, 0);
        chk("sq_final_data", wdata, 32'h5A);
        chk("sq_final_addr", waddr, 9);

        // address 0 aux entry
        drive(0, 0, 0, 1, 0, 32'h77);
        nx();
        chk("a0_pend1", aux_pending, 1);
        drive(0, 0, 0, 0, 0, 0);
        nx();
        chk("a0_no_wen", w_en, 0);
        chk("a0_src", wr_src, 0);
        chk("a0_pend0", aux_pending, 0);
        chk("a0_hold_data", wdata, 32'h5A);

        // asynchronous reset with two entries queued
        drive(1, 1, 32'hE0, 1, 3, 32'hF0);
        nx();
        drive(1, 1, 32'hE1, 1, 4, 32'hF1);
        nx();
        chk("ar_pend2", aux_pending, 2);
        chk("ar_w_en_before", w_en, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_w_en", w_en, 0);
        chk("ar_pend", aux_pending, 0);
        chk("ar_aux_ready", aux_ready, 0);
        chk("ar_src", wr_src, 0);
        drive(0, 0, 0, 0, 0, 0);
        nx(); rst_n = 1'b1;
        nx();
        chk("ar_after_w_en", w_en, 0);
        chk("ar_after_pend", aux_pending, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
